store_a_sweep_ctrl: RTL and testbench

Sequencer that sweeps the pair-addressed matrix store (`store_A`) row-pair by row-pair or column-pair by column-pair. For each pair it reads the pair, hands it to a rotation/processing unit over a valid/ready handshake, accepts the processed pair back, and writes it to the same location. It sits between the SVD top-level control, which issues start, and the `store_A` instance plus one processing unit.

---
 rtl/store_a_pkg.sv | 40 ++++
 rtl/store_a_sweep_ctrl.sv | 138 +++++++++++++
 tb/tb_store_a_sweep_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/store_a_pkg.sv
// Shared definitions for store_A users: sweep FSM states, address field layout
// and the pair-address helper used by the sweep controller.
package store_a_pkg;

   localparam int unsigned ADDR_W  = 6;
   localparam int unsigned RC_POS  = 5;
   localparam int unsigned ROW_POS = 2;
   localparam int unsigned ROW_W   = 3;
   localparam int unsigned COL_POS = 0;
   localparam int unsigned COL_W   = 2;
   localparam int unsigned PAIR_W  = 2 * 24 * 8;

   localparam logic [ROW_W-1:0] ROW_IDX_MAX = 3'd7;
   localparam logic [ROW_W-1:0] COL_IDX_MAX = 3'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_LATCH,
      S_SEND,
      S_WAIT_RES,
      S_WR,
      S_DONE
   } sweep_state_e;

   // Row pairs live in the RCn=1 half at column 0; column pairs sit in row 0.
   function automatic logic [ADDR_W-1:0] pair_addr(input logic row_mode,
                                                  input logic [ROW_W-1:0] idx);
      logic [ADDR_W-1:0] a;
      a = '0;
      if (row_mode) begin
         a[RC_POS]             = 1'b1;
         a[ROW_POS +: ROW_W]   = idx;
      end else begin
         a[COL_POS +: COL_W]   = idx[COL_W-1:0];
      end
      return a;
   endfunction

endpackage

// File: rtl/store_a_sweep_ctrl.sv
// Sweeps store_A pair by pair: read, hand to the processing unit, take the
// result back and write it to the same address, stepping the index by two.
module store_a_sweep_ctrl #(
   parameter int unsigned DATA_WIDTH = 24,
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned PAIR_W     = 2 * DATA_WIDTH * 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  mode,
   input  logic [2:0]            first,
   input  logic [2:0]            last,
   output logic                  busy,
   output logic                  done,
   output logic                  st_we,
   output logic [ADDR_WIDTH-1:0] st_addr,
   output logic [PAIR_W-1:0]     st_din,
   input  logic [PAIR_W-1:0]     st_dout,
   output logic                  pu_valid,
   input  logic                  pu_ready,
   output logic [PAIR_W-1:0]     pu_data,
   output logic [2:0]            pu_idx,
   input  logic                  res_valid,
   output logic                  res_ready,
   input  logic [PAIR_W-1:0]     res_data
);
   import store_a_pkg::*;

   sweep_state_e          state_q;
   logic                  mode_q;
   logic [3:0]            idx_q;
   logic [2:0]            bound_q;
   logic                  busy_q, done_q, st_we_q, pu_valid_q, res_ready_q;
   logic [ADDR_WIDTH-1:0] st_addr_q;
   logic [PAIR_W-1:0]     st_din_q, pu_data_q;
   logic [2:0]            pu_idx_q;

   logic [3:0]            start_idx_d;
   logic [2:0]            start_bound_d;
   logic [3:0]            idx_d;

   // Column mode only looks at the low two bits of first/last (bound 0..3).
   always_comb begin
      start_idx_d   = mode ? {1'b0, first} : {2'b00, first[1:0]};
      start_bound_d = mode ? last : {1'b0, last[1:0]};
      idx_d         = idx_q + 4'd2;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mode_q      <= 1'b0;
         idx_q       <= '0;
         bound_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         st_we_q     <= 1'b0;
         st_addr_q   <= '0;
         st_din_q    <= '0;
         pu_valid_q  <= 1'b0;
         pu_data_q   <= '0;
         pu_idx_q    <= '0;
         res_ready_q <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         st_we_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  mode_q  <= mode;
                  idx_q   <= start_idx_d;
                  bound_q <= start_bound_d;
                  busy_q  <= 1'b1;
                  if (start_idx_d <= {1'b0, start_bound_d}) begin
                     state_q   <= S_RD;
                     st_addr_q <= ADDR_WIDTH'(pair_addr(mode, start_idx_d[2:0]));
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_RD: state_q <= S_LATCH;
            S_LATCH: begin
               pu_data_q  <= st_dout;
               pu_idx_q   <= idx_q[2:0];
               pu_valid_q <= 1'b1;
               state_q    <= S_SEND;
            end
            S_SEND: begin
               if (pu_ready) begin
                  pu_valid_q  <= 1'b0;
                  res_ready_q <= 1'b1;
                  state_q     <= S_WAIT_RES;
               end
            end
            S_WAIT_RES: begin
               if (res_valid) begin
                  res_ready_q <= 1'b0;
                  st_din_q    <= res_data;
                  st_we_q     <= 1'b1;
                  state_q     <= S_WR;
               end
            end
            S_WR: begin
               // 4-bit index so 6+2 and 2+2 compare past the bound instead of wrapping.
               idx_q <= idx_d;
               if (idx_d > {1'b0, bound_q}) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q   <= S_RD;
                  st_addr_q <= ADDR_WIDTH'(pair_addr(mode_q, idx_d[2:0]));
               end
            end
            S_DONE: begin
               busy_q    <= 1'b0;
               st_addr_q <= '0;
               st_din_q  <= '0;
               state_q   <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign st_we     = st_we_q;
   assign st_addr   = st_addr_q;
   assign st_din    = st_din_q;
   assign pu_valid  = pu_valid_q;
   assign pu_data   = pu_data_q;
   assign pu_idx    = pu_idx_q;
   assign res_ready = res_ready_q;

endmodule

// File: tb/tb_store_a_sweep_ctrl.sv
// Directed bench for store_a_sweep_ctrl with a behavioural store_A and a PU
// that returns input+1 after a programmable handshake delay.
module tb_store_a_sweep_ctrl;

   localparam int PW = 384;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          mode = 1'b0;
   logic [2:0]    first = '0;
   logic [2:0]    last = '0;
   logic          busy, done, st_we, pu_valid, pu_ready, res_valid, res_ready;
   logic [5:0]    st_addr;
   logic [PW-1:0] st_din, st_dout, pu_data, res_data;
   logic [2:0]    pu_idx;

   int total = 0;
   int bad   = 0;

   logic [PW-1:0] mem [64];
   int            ready_wait = 0;
   int            res_wait   = 0;
   int            vcnt, wcnt;
   logic [PW-1:0] pu_hold;

   logic [5:0]    wr_q[$];
   logic [2:0]    idx_q[$];
   logic [PW-1:0] pdat_q[$];
   int            pv_cnt;
   int            unstable;
   int            early_we;

   store_a_sweep_ctrl #(.DATA_WIDTH(24), .ADDR_WIDTH(6), .PAIR_W(PW)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .first(first), .last(last),
      .busy(busy), .done(done), .st_we(st_we), .st_addr(st_addr), .st_din(st_din),
      .st_dout(st_dout), .pu_valid(pu_valid), .pu_ready(pu_ready), .pu_data(pu_data),
      .pu_idx(pu_idx), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (st_we) mem[st_addr] <= st_din;
      st_dout <= mem[st_addr];
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         vcnt <= 0; wcnt <= 0; pu_hold <= '0;
      end else begin
         vcnt <= (pu_valid && !pu_ready) ? vcnt + 1 : 0;
         wcnt <= (res_ready && !res_valid) ? wcnt + 1 : 0;
         if (pu_valid && pu_ready) pu_hold <= pu_data + PW'(1);
      end
   end
   assign pu_ready  = pu_valid && (vcnt >= ready_wait);
   assign res_valid = res_ready && (wcnt >= res_wait);
   assign res_data  = pu_hold;

   function automatic logic [PW-1:0] init_val(input int a);
      return PW'(64'h00AB_0000_0000) + PW'(a * 16 + 5);
   endfunction

   // Runs one sweep started at edge E; done_at is k where done is seen in cycle E+k.
   task automatic run_sweep(input logic m, input logic [2:0] f, input logic [2:0] l,
                            input int maxc, input int poke_at,
                            output int done_at, output logic busy_after);
      logic          have_ref;
      logic [PW-1:0] ref_d;
      logic [2:0]    ref_i;
      wr_q.delete(); idx_q.delete(); pdat_q.delete();
      pv_cnt = 0; unstable = 0; early_we = 0; done_at = -1; have_ref = 1'b0;
      ref_d = '0; ref_i = '0;
      @(negedge clk);
      start = 1'b1; mode = m; first = f; last = l;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= maxc; k++) begin
         if (st_we) wr_q.push_back(st_addr);
         if (st_we && (pu_valid || res_ready)) early_we++;
         if (pu_valid) begin
            pv_cnt++;
            if (!have_ref) begin
               have_ref = 1'b1; ref_d = pu_data; ref_i = pu_idx;
               idx_q.push_back(pu_idx); pdat_q.push_back(pu_data);
            end else if (pu_data !== ref_d || pu_idx !== ref_i) begin
               unstable++;
            end
            if (pu_ready) have_ref = 1'b0;
         end
         if (done) begin
            done_at = k;
            break;
         end
         if (k == poke_at) begin
            start = 1'b1; mode = ~m; first = 3'd1; last = 3'd3;
         end
         @(posedge clk); #1;
         start = 1'b0; mode = m; first = f; last = l;
      end
      @(posedge clk); #1;
      busy_after = busy;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if ({busy, done, st_we, pu_valid, res_ready} !== 5'b0) begin bad++;
         $display("FAIL reset_ctrl got=%b want=00000", {busy, done, st_we, pu_valid, res_ready}); end
      total++; if (st_addr !== 6'h00) begin bad++; $display("FAIL reset_addr got=%h want=00", st_addr); end
      total++; if (st_din !== '0) begin bad++; $display("FAIL reset_din got nonzero want=0"); end
      total++; if (pu_data !== '0) begin bad++; $display("FAIL reset_pu_data got nonzero want=0"); end
      total++; if (pu_idx !== 3'd0) begin bad++; $display("FAIL reset_pu_idx got=%0d want=0", pu_idx); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_empty();
      int d; logic b;
      run_sweep(1'b1, 3'd5, 3'd2, 10, 0, d, b);
      total++; if (d !== 1) begin bad++; $display("FAIL empty_done got=%0d want=1", d); end
      total++; if (wr_q.size() !== 0) begin bad++; $display("FAIL empty_writes got=%0d want=0", wr_q.size()); end
      total++; if (pv_cnt !== 0) begin bad++; $display("FAIL empty_pu_valid got=%0d want=0", pv_cnt); end
      total++; if (b !== 1'b0) begin bad++; $display("FAIL empty_busy_after got=%b want=0", b); end
   endtask

   task automatic test_row_sweep();
      int d; logic b;
      logic [5:0] exp_a [4];
      exp_a[0] = 6'h20; exp_a[1] = 6'h28; exp_a[2] = 6'h30; exp_a[3] = 6'h38;
      run_sweep(1'b1, 3'd0, 3'd6, 40, 0, d, b);
      total++; if (d !== 21) begin bad++; $display("FAIL row_done got=%0d want=21", d); end
      total++; if (b !== 1'b0) begin bad++; $display("FAIL row_busy_fall got=%b want=0", b); end
      total++; if (wr_q.size() !== 4) begin bad++; $display("FAIL row_nwrites got=%0d want=4", wr_q.size()); end
      for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
         total++; if (wr_q[i] !== exp_a[i]) begin bad++;
            $display("FAIL row_waddr[%0d] got=%h want=%h", i, wr_q[i], exp_a[i]); end
         total++; if (mem[exp_a[i]] !== init_val(exp_a[i]) + PW'(1)) begin bad++;
            $display("FAIL row_mem[%h] low got=%h want=%h", exp_a[i], mem[exp_a[i]][31:0],
                     init_val(exp_a[i]) + PW'(1)); end
      end
      total++; if (mem[6'h24] !== init_val(6'h24)) begin bad++; $display("FAIL row_untouched_24 changed"); end
   endtask

   task automatic test_col_sweep();
      int d; logic b;
      run_sweep(1'b0, 3'd1, 3'd3, 30, 0, d, b);
      total++; if (d !== 11) begin bad++; $display("FAIL col_done got=%0d want=11", d); end
      total++; if (wr_q.size() !== 2) begin bad++; $display("FAIL col_nwrites got=%0d want=2", wr_q.size()); end
      else begin
         total++; if (wr_q[0] !== 6'h01 || wr_q[1] !== 6'h03) begin bad++;
            $display("FAIL col_waddr got=%h,%h want=01,03", wr_q[0], wr_q[1]); end
      end
      total++; if (idx_q.size() !== 2) begin bad++; $display("FAIL col_noffers got=%0d want=2", idx_q.size()); end
      else begin
         total++; if (idx_q[0] !== 3'd1 || idx_q[1] !== 3'd3) begin bad++;
            $display("FAIL col_pu_idx got=%0d,%0d want=1,3", idx_q[0], idx_q[1]); end
         total++; if (pdat_q[0] !== init_val(1)) begin bad++;
            $display("FAIL col_pu_data got=%h want=%h", pdat_q[0][31:0], init_val(1)); end
      end
      total++; if (mem[6'h03] !== init_val(3) + PW'(1)) begin bad++; $display("FAIL col_mem3 not incremented"); end
      total++; if (mem[6'h02] !== init_val(2)) begin bad++; $display("FAIL col_mem2 changed"); end
   endtask

   task automatic test_backpressure();
      int d; logic b;
      ready_wait = 3; res_wait = 2;
      run_sweep(1'b1, 3'd2, 3'd2, 30, 0, d, b);
      ready_wait = 0; res_wait = 0;
      total++; if (d !== 11) begin bad++; $display("FAIL bp_done got=%0d want=11", d); end
      total++; if (unstable !== 0) begin bad++; $display("FAIL bp_stable got=%0d want=0", unstable); end
      total++; if (pv_cnt !== 4) begin bad++; $display("FAIL bp_valid_cycles got=%0d want=4", pv_cnt); end
      total++; if (early_we !== 0 || wr_q.size() !== 1) begin bad++;
         $display("FAIL bp_write got early=%0d n=%0d want=0,1", early_we, wr_q.size()); end
      total++; if (idx_q.size() !== 1 || idx_q[0] !== 3'd2) begin bad++; $display("FAIL bp_pu_idx want=2"); end
   endtask

   task automatic test_start_while_busy();
      int d; logic b;
      run_sweep(1'b1, 3'd0, 3'd2, 30, 3, d, b);
      total++; if (d !== 11) begin bad++; $display("FAIL busy_start_done got=%0d want=11", d); end
      total++; if (wr_q.size() !== 2) begin bad++; $display("FAIL busy_start_nwrites got=%0d want=2", wr_q.size()); end
      else begin
         total++; if (wr_q[0] !== 6'h20 || wr_q[1] !== 6'h28) begin bad++;
            $display("FAIL busy_start_waddr got=%h,%h want=20,28", wr_q[0], wr_q[1]); end
      end
   endtask

   task automatic test_reset_midstream();
      int d; logic b; int n;
      res_wait = 100;
      @(negedge clk);
      start = 1'b1; mode = 1'b1; first = 3'd0; last = 3'd6;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!res_ready && n < 10) begin @(posedge clk); #1; n++; end
      total++; if (res_ready !== 1'b1) begin bad++; $display("FAIL mid_reach_wait got=%b want=1", res_ready); end
      #2 rst = 1'b1;
      #1;
      total++; if ({busy, done, st_we, pu_valid, res_ready} !== 5'b0 || st_addr !== 6'h00) begin bad++;
         $display("FAIL mid_reset_ctrl got=%b addr=%h want=00000 addr=00",
                  {busy, done, st_we, pu_valid, res_ready}, st_addr); end
      total++; if (st_din !== '0 || pu_data !== '0 || pu_idx !== 3'd0) begin bad++;
         $display("FAIL mid_reset_data got nonzero want=0"); end
      res_wait = 0;
      @(negedge clk);
      rst = 1'b0;
      run_sweep(1'b1, 3'd0, 3'd0, 20, 0, d, b);
      total++; if (d !== 6) begin bad++; $display("FAIL mid_after_done got=%0d want=6", d); end
      total++; if (wr_q.size() !== 1 || wr_q[0] !== 6'h20) begin bad++; $display("FAIL mid_after_write want one at 20"); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = init_val(i);
      test_reset();
      test_empty();
      test_row_sweep();
      test_col_sweep();
      test_backpressure();
      test_start_while_busy();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
